// File: rtl/jk_flip_flop_if.sv
// Signal bundle for a jk_flip_flop bank: J/K drive side and state/observe side.
// Latency: none (wires only); the flop bank itself is one cycle J/K to q.
// Backpressure: none; every rising clock edge samples J/K unconditionally.
interface jk_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
`ifdef JK_FF_CHG_EN
    logic [WIDTH-1:0] chg;
`endif

    // Master drives J/K and observes the state bits.
    modport master (
        output j,
        output k,
        input  q,
        input  qn
`ifdef JK_FF_CHG_EN
        ,
        input  chg
`endif
    );

    // Slave is the flop bank: consumes J/K and produces the state bits.
    modport slave (
        input  j,
        input  k,
        output q,
        output qn
`ifdef JK_FF_CHG_EN
        ,
        output chg
`endif
    );
endinterface

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent rising-edge JK flip-flops with async active-low reset.
// Latency: q updates on the sampling edge (1 cycle); qn is combinational from q.
// Backpressure: none. Optional change pulse chg enabled by defining JK_FF_CHG_EN.
module jk_flip_flop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    input  logic             rst_n,
    output logic [WIDTH-1:0] qn
`ifdef JK_FF_CHG_EN
    ,
    output logic [WIDTH-1:0] chg
`endif
);

    logic [WIDTH-1:0] q_nxt;

    // Per-bit JK next-state: hold, reset, set or toggle; bits never interact.
    always_comb begin
        q_nxt = q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                2'b00:   q_nxt[i] = q[i];
                2'b01:   q_nxt[i] = 1'b0;
                2'b10:   q_nxt[i] = 1'b1;
                2'b11:   q_nxt[i] = ~q[i];
                default: q_nxt[i] = q_nxt[i] ^ j[i] ^ k[i]; // lets X on j/k reach q
            endcase
        end
    end

    // State register; reset is asynchronous and overrides any clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= q_nxt;
        end
    end

    // Complement is derived from q so the two outputs can never disagree.
    assign qn = ~q;

`ifdef JK_FF_CHG_EN
    // Change pulse: high for the cycle following any edge that flipped the bit,
    // so redundant set/reset and hold leave it low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= {WIDTH{1'b0}};
        end else begin
            chg <= q_nxt ^ q;
        end
    end
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench for jk_flip_flop: a WIDTH=1 bank and a WIDTH=4 bank (nonzero reset value).
// Inputs are driven on the falling edge; outputs are checked 1 time unit after the rising edge.
// Change-pulse checks are active only when JK_FF_CHG_EN is defined.
module tb_jk_flip_flop;

    logic clk;
    logic rst_n;

    jk_flip_flop_if #(.WIDTH(1)) if1 ();
    jk_flip_flop_if #(.WIDTH(4)) if4 ();

    jk_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) u1 (
        .j     (if1.j),
        .k     (if1.k),
        .clk   (clk),
        .q     (if1.q),
        .rst_n (rst_n),
        .qn    (if1.qn)
`ifdef JK_FF_CHG_EN
        ,
        .chg   (if1.chg)
`endif
    );

    jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'b0101)) u4 (
        .j     (if4.j),
        .k     (if4.k),
        .clk   (clk),
        .q     (if4.q),
        .rst_n (rst_n),
        .qn    (if4.qn)
`ifdef JK_FF_CHG_EN
        ,
        .chg   (if4.chg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic       j1;
        logic       k1;
        logic       q1;   // expected WIDTH=1 state after the edge
        logic [3:0] j4;
        logic [3:0] k4;
        logic [3:0] q4;   // expected WIDTH=4 state after the edge
    } vec_t;

    vec_t tbl[11];

    task automatic drive(input logic j1, input logic k1, input logic [3:0] j4, input logic [3:0] k4);
        @(negedge clk);
        if1.j = j1;
        if1.k = k1;
        if4.j = j4;
        if4.k = k4;
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       prev1;
        logic [3:0] prev4;

        // Walks q1 through set/reset/toggle/hold and a 4-edge toggle run from 0;
        // walks q4 through mixed per-bit operations.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b1010, 4'b0101};
        // bit3 toggle 0->1, bit2 set (1), bit1 reset (0), bit0 hold (1)
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'b1100, 4'b1010, 4'b1101};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1101};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0010};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0011};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1111};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'b1010, 4'b1010, 4'b0101};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'b0110, 4'b0011, 4'b0110};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'b1001, 4'b1001, 4'b1111};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111};

        // Reset held with clock running and J=K=1 everywhere: clock edges ignored.
        rst_n  = 1'b0;
        if1.j  = 1'b1;
        if1.k  = 1'b1;
        if4.j  = 4'b1111;
        if4.k  = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("reset q1",  {3'b0, if1.q},  4'b0000);
        check("reset qn1", {3'b0, if1.qn}, 4'b0001);
        check("reset q4",  if4.q,  4'b0101);
        check("reset qn4", if4.qn, 4'b1010);
`ifdef JK_FF_CHG_EN
        check("reset chg1", {3'b0, if1.chg}, 4'b0000);
        check("reset chg4", if4.chg, 4'b0000);
`endif

        // Release between edges; the very next edge toggles.
        @(negedge clk);
        rst_n = 1'b1;
        edge_then_sample();
        check("release q1", {3'b0, if1.q}, 4'b0001);
        check("release q4", if4.q, 4'b1010);
`ifdef JK_FF_CHG_EN
        check("release chg1", {3'b0, if1.chg}, 4'b0001);
        check("release chg4", if4.chg, 4'b1111);
`endif

        prev1 = 1'b1;
        prev4 = 4'b1010;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].j1, tbl[i].k1, tbl[i].j4, tbl[i].k4);
            edge_then_sample();
            check($sformatf("vec%0d q1", i),  {3'b0, if1.q},  {3'b0, tbl[i].q1});
            check($sformatf("vec%0d qn1", i), {3'b0, if1.qn}, {3'b0, ~tbl[i].q1});
            check($sformatf("vec%0d q4", i),  if4.q,  tbl[i].q4);
            check($sformatf("vec%0d qn4", i), if4.qn, ~tbl[i].q4);
`ifdef JK_FF_CHG_EN
            check($sformatf("vec%0d chg1", i), {3'b0, if1.chg}, {3'b0, prev1 ^ tbl[i].q1});
            check($sformatf("vec%0d chg4", i), if4.chg, prev4 ^ tbl[i].q4);
`endif
            prev1 = tbl[i].q1;
            prev4 = tbl[i].q4;
        end

        // Async reset mid-cycle with q1=1: takes effect before any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async q1",  {3'b0, if1.q},  4'b0000);
        check("async qn1", {3'b0, if1.qn}, 4'b0001);
        check("async q4",  if4.q, 4'b0101);
        // Edge during reset with set requested: still held.
        if1.j = 1'b1;
        if1.k = 1'b0;
        edge_then_sample();
        check("held q1", {3'b0, if1.q}, 4'b0000);
`ifdef JK_FF_CHG_EN
        check("held chg1", {3'b0, if1.chg}, 4'b0000);
`endif

        // Release, set q1, then assert reset on the same instant as an edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000);
        edge_then_sample();
        check("set q1", {3'b0, if1.q}, 4'b0001);
        @(negedge clk);
        if1.j = 1'b1;
        if1.k = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("coincident q1", {3'b0, if1.q}, 4'b0000);
        check("coincident q4", if4.q, 4'b0101);
        @(negedge clk);
        rst_n = 1'b1;

        // From q1=0: set, redundant set, reset, hold.
        drive(1'b1, 1'b0, 4'b0000, 4'b0000);
        edge_then_sample();
        check("seq set q1", {3'b0, if1.q}, 4'b0001);
`ifdef JK_FF_CHG_EN
        check("seq set chg1", {3'b0, if1.chg}, 4'b0001);
`endif
        drive(1'b1, 1'b0, 4'b0000, 4'b0000);
        edge_then_sample();
        check("seq reset-redundant q1", {3'b0, if1.q}, 4'b0001);
`ifdef JK_FF_CHG_EN
        check("seq redundant chg1", {3'b0, if1.chg}, 4'b0000);
`endif
        drive(1'b0, 1'b1, 4'b0000, 4'b0000);
        edge_then_sample();
        check("seq clear q1", {3'b0, if1.q}, 4'b0000);
`ifdef JK_FF_CHG_EN
        check("seq clear chg1", {3'b0, if1.chg}, 4'b0001);
`endif
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        edge_then_sample();
        check("seq hold q1", {3'b0, if1.q}, 4'b0000);
        check("seq hold q4", if4.q, 4'b0101);
`ifdef JK_FF_CHG_EN
        check("seq hold chg1", {3'b0, if1.chg}, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
